// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- 16-bit signed ALU with registered overflow (V) and zero (Z) flags.
//
// Ports
//   clk           in   1   rising-edge clock
//   rst           in   1   synchronous active-high reset (clears flags only)
//   R1            in  16   operand A, two's-complement
//   R2            in  16   operand B / shift amount / immediate byte
//   alu_code      in   4   operation select
//   alu_output    out 16   combinational result
//   overflow_flag out  1   registered saturation flag (ADD/SUB)
//   zero_flag     out  1   registered zero flag (ADD/SUB/XOR/SLL/SRA/ROR)
//
// The result path is purely combinational; the two flag bits are the only
// state in the block.
// ---------------------------------------------------------------------------
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] R1,
  input  logic [15:0] R2,
  input  logic [3:0]  alu_code,
  output logic [15:0] alu_output,
  output logic        overflow_flag,
  output logic        zero_flag
);

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LLB    = 4'b1010;
  localparam logic [3:0] OP_LHB    = 4'b1011;

  logic [15:0] sum_raw_s;
  logic [15:0] diff_raw_s;
  logic        add_ovf_s;
  logic        sub_ovf_s;
  logic [15:0] add_sat_s;
  logic [15:0] sub_sat_s;
  logic [9:0]  red_s;
  logic [31:0] rot_wide_s;
  logic [15:0] sra_s;
  logic [15:0] paddsb_s;
  logic [3:0]  nib_sum_s;
  logic [3:0]  nib_a_s;
  logic [3:0]  nib_b_s;
  logic        sat_s;
  logic [15:0] result_s;

  logic overflow_q, overflow_d;
  logic zero_q, zero_d;

  // Datapath: all candidate results and the final output mux.
  always_comb begin
    sum_raw_s  = R1 + R2;
    diff_raw_s = R1 - R2;

    // Overflow only when operand signs make it possible and the raw sign
    // disagrees with A; carry-out is deliberately ignored.
    add_ovf_s = (R1[15] == R2[15]) && (sum_raw_s[15] != R1[15]);
    sub_ovf_s = (R1[15] != R2[15]) && (diff_raw_s[15] != R1[15]);

    // Saturate toward the sign of A: A positive -> 7FFF, A negative -> 8000.
    if (add_ovf_s) begin
      add_sat_s = R1[15] ? 16'h8000 : 16'h7FFF;
    end else begin
      add_sat_s = sum_raw_s;
    end
    if (sub_ovf_s) begin
      sub_sat_s = R1[15] ? 16'h8000 : 16'h7FFF;
    end else begin
      sub_sat_s = diff_raw_s;
    end

    // Four signed bytes summed at 10 bits; range [-512, 508] never wraps.
    red_s = {{2{R1[15]}}, R1[15:8]} + {{2{R1[7]}}, R1[7:0]}
          + {{2{R2[15]}}, R2[15:8]} + {{2{R2[7]}}, R2[7:0]};

    rot_wide_s = {R1, R1} >> R2[3:0];
    sra_s      = $signed(R1) >>> R2[3:0];

    // Nibble-wise saturating add; each lane is independent.
    paddsb_s  = 16'h0000;
    nib_sum_s = 4'h0;
    nib_a_s   = 4'h0;
    nib_b_s   = 4'h0;
    for (int k = 0; k < 4; k++) begin
      nib_a_s   = R1[4*k +: 4];
      nib_b_s   = R2[4*k +: 4];
      nib_sum_s = nib_a_s + nib_b_s;
      if ((nib_a_s[3] == nib_b_s[3]) && (nib_sum_s[3] != nib_a_s[3])) begin
        paddsb_s[4*k +: 4] = nib_a_s[3] ? 4'h8 : 4'h7;
      end else begin
        paddsb_s[4*k +: 4] = nib_sum_s;
      end
    end

    sat_s = 1'b0;
    case (alu_code)
      OP_ADD: begin
        result_s = add_sat_s;
        sat_s    = add_ovf_s;
      end
      OP_SUB: begin
        result_s = sub_sat_s;
        sat_s    = sub_ovf_s;
      end
      OP_XOR:    result_s = R1 ^ R2;
      OP_RED:    result_s = {{6{red_s[9]}}, red_s};
      OP_SLL:    result_s = R1 << R2[3:0];
      OP_SRA:    result_s = sra_s;
      OP_ROR:    result_s = rot_wide_s[15:0];
      OP_PADDSB: result_s = paddsb_s;
      OP_LLB:    result_s = {R1[15:8], R2[7:0]};
      OP_LHB:    result_s = {R2[7:0], R1[7:0]};
      // 1000/1001 address calc and 1100-1111 branch add: plain wrap add.
      default:   result_s = sum_raw_s;
    endcase
  end

  assign alu_output = result_s;

  // Flag next-state: which flags each opcode is allowed to touch.
  always_comb begin
    overflow_d = overflow_q;
    zero_d     = zero_q;
    case (alu_code)
      OP_ADD, OP_SUB: begin
        overflow_d = sat_s;
        zero_d     = (result_s == 16'h0000);
      end
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
        zero_d = (result_s == 16'h0000);
      end
      default: begin
        overflow_d = overflow_q;
        zero_d     = zero_q;
      end
    endcase
  end

  // Flag registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign overflow_flag = overflow_q;
  assign zero_flag     = zero_q;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu: directed cases plus randomized
// operations compared against an integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu;

  logic        clk;
  logic        rst;
  logic [15:0] R1;
  logic [15:0] R2;
  logic [3:0]  alu_code;
  logic [15:0] alu_output;
  logic        overflow_flag;
  logic        zero_flag;

  int total;
  int bad;

  bit m_ovf;
  bit m_z;

  alu dut (
    .clk           (clk),
    .rst           (rst),
    .R1            (R1),
    .R2            (R2),
    .alu_code      (alu_code),
    .alu_output    (alu_output),
    .overflow_flag (overflow_flag),
    .zero_flag     (zero_flag)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sb8(input logic [7:0] v);
    return (v >= 8'd128) ? int'(v) - 256 : int'(v);
  endfunction

  function automatic int sn4(input logic [3:0] v);
    return (v >= 4'd8) ? int'(v) - 16 : int'(v);
  endfunction

  // Reference model: plain integer arithmetic on the operation definitions.
  task automatic ref_alu(input logic [3:0] code, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] res, output bit sat);
    int sa, sb, t, ua, amt, p, m, n;
    logic [31:0] tw;
    sa  = sb8(a[15:8]) * 256 + int'(a[7:0]);
    sb  = sb8(b[15:8]) * 256 + int'(b[7:0]);
    ua  = int'(a);
    amt = int'(b[3:0]);
    sat = 1'b0;
    case (code)
      4'd0, 4'd1: begin
        t = (code == 4'd0) ? sa + sb : sa - sb;
        if (t > 32767) begin t = 32767; sat = 1'b1; end
        else if (t < -32768) begin t = -32768; sat = 1'b1; end
        tw = t; res = tw[15:0];
      end
      4'd2: res = a ^ b;
      4'd3: begin
        t = sb8(a[15:8]) + sb8(a[7:0]) + sb8(b[15:8]) + sb8(b[7:0]);
        tw = t; res = tw[15:0];
      end
      4'd4: begin
        tw = ua * (1 << amt); res = tw[15:0];
      end
      4'd5: begin
        p = 1 << amt;
        m = ((sa % p) + p) % p;
        t = (sa - m) / p;
        tw = t; res = tw[15:0];
      end
      4'd6: begin
        tw = (ua >> amt) | ((ua << (16 - amt)) & 32'hFFFF);
        res = tw[15:0];
      end
      4'd7: begin
        res = 16'h0000;
        for (int k = 0; k < 4; k++) begin
          n = sn4(a[4*k +: 4]) + sn4(b[4*k +: 4]);
          if (n > 7) n = 7;
          if (n < -8) n = -8;
          tw = n;
          res[4*k +: 4] = tw[3:0];
        end
      end
      4'd10: res = {a[15:8], b[7:0]};
      4'd11: res = {b[7:0], a[7:0]};
      default: begin
        tw = ua + int'(b); res = tw[15:0];
      end
    endcase
  endtask

  // Apply one operation, check the combinational result mid-cycle, clock it,
  // then check both flags against the model.
  task automatic do_op(input logic [3:0] code, input logic [15:0] a, input logic [15:0] b,
                       input logic r);
    logic [15:0] e;
    bit s;
    @(negedge clk);
    alu_code = code; R1 = a; R2 = b; rst = r;
    ref_alu(code, a, b, e, s);
    #5;
    chk($sformatf("out op%0d", code), alu_output, e);
    if (r) begin
      m_ovf = 1'b0; m_z = 1'b0;
    end else if (code == 4'd0 || code == 4'd1) begin
      m_ovf = s; m_z = (e == 16'h0000);
    end else if (code == 4'd2 || code == 4'd4 || code == 4'd5 || code == 4'd6) begin
      m_z = (e == 16'h0000);
    end
    @(posedge clk);
    #1;
    chk($sformatf("ovf op%0d", code), {15'd0, overflow_flag}, {15'd0, m_ovf});
    chk($sformatf("z op%0d", code), {15'd0, zero_flag}, {15'd0, m_z});
  endtask

  initial begin
    total = 0; bad = 0;
    m_ovf = 1'b0; m_z = 1'b0;
    rst = 1'b1; R1 = 16'h0000; R2 = 16'h0000; alu_code = 4'd2;
    @(posedge clk); @(posedge clk); #1;
    chk("reset ovf", {15'd0, overflow_flag}, 16'h0000);
    chk("reset z", {15'd0, zero_flag}, 16'h0000);
    @(negedge clk); rst = 1'b0;

    // Saturating ADD / SUB corners
    do_op(4'd0, 16'h7000, 16'h2000, 1'b0);
    chk("add pos sat", alu_output, 16'h7FFF);
    chk("add pos ovf", {15'd0, overflow_flag}, 16'h0001);
    chk("add pos z", {15'd0, zero_flag}, 16'h0000);
    do_op(4'd0, 16'h8000, 16'hFFFF, 1'b0);
    chk("add neg sat", alu_output, 16'h8000);
    chk("add neg ovf", {15'd0, overflow_flag}, 16'h0001);
    do_op(4'd0, 16'h0005, 16'hFFFB, 1'b0);
    chk("add zero out", alu_output, 16'h0000);
    chk("add zero z", {15'd0, zero_flag}, 16'h0001);
    chk("add zero ovf", {15'd0, overflow_flag}, 16'h0000);
    do_op(4'd1, 16'h8000, 16'h0001, 1'b0);
    chk("sub neg sat", alu_output, 16'h8000);
    do_op(4'd1, 16'h7FFF, 16'hFFFF, 1'b0);
    chk("sub pos sat", alu_output, 16'h7FFF);
    do_op(4'd1, 16'h0010, 16'h0003, 1'b0);
    chk("sub plain", alu_output, 16'h000D);
    // Carry-out without signed overflow must not saturate.
    do_op(4'd0, 16'hFFFF, 16'hFFFF, 1'b0);
    chk("add carry", alu_output, 16'hFFFE);

    // XOR sweep
    for (int i = 0; i < 100; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom); b = 16'($urandom);
      do_op(4'd2, a, b, 1'b0);
      chk("xor sweep", alu_output, a ^ b);
    end
    do_op(4'd2, 16'hA5A5, 16'hA5A5, 1'b0);
    chk("xor self z", {15'd0, zero_flag}, 16'h0001);

    // Shifts and PADDSB
    do_op(4'd4, 16'h8001, 16'h0004, 1'b0);
    chk("sll", alu_output, 16'h0010);
    do_op(4'd5, 16'h8001, 16'h0004, 1'b0);
    chk("sra", alu_output, 16'hF800);
    do_op(4'd6, 16'h8001, 16'h0004, 1'b0);
    chk("ror", alu_output, 16'h1800);
    do_op(4'd6, 16'h8001, 16'h0000, 1'b0);
    chk("ror zero", alu_output, 16'h8001);
    do_op(4'd7, 16'h7171, 16'h1111, 1'b0);
    chk("paddsb", alu_output, 16'h7272);
    do_op(4'd7, 16'h8888, 16'h8F8F, 1'b0);
    chk("paddsb neg", alu_output, 16'h8888);
    do_op(4'd3, 16'h7F7F, 16'h7F7F, 1'b0);
    chk("red max", alu_output, 16'h01FC);

    // Reset and hold: set both flags, then reset, then a non-flag op.
    do_op(4'd0, 16'h7000, 16'h2000, 1'b0);
    do_op(4'd2, 16'hA5A5, 16'hA5A5, 1'b0);
    chk("pre-rst ovf", {15'd0, overflow_flag}, 16'h0001);
    chk("pre-rst z", {15'd0, zero_flag}, 16'h0001);
    do_op(4'd0, 16'h0005, 16'hFFFB, 1'b1);
    chk("rst ovf", {15'd0, overflow_flag}, 16'h0000);
    chk("rst z", {15'd0, zero_flag}, 16'h0000);
    chk("rst out tracks", alu_output, 16'h0000);
    do_op(4'd10, 16'h1234, 16'h00AB, 1'b0);
    chk("llb", alu_output, 16'h12AB);
    chk("llb hold ovf", {15'd0, overflow_flag}, 16'h0000);
    chk("llb hold z", {15'd0, zero_flag}, 16'h0000);

    // Randomized mix over all opcodes, with biased operands and rare resets.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a, b;
      logic [3:0] c;
      c = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: begin a = 16'h7FFF - 16'($urandom_range(0, 3)); b = 16'($urandom); end
        1: begin a = 16'h8000 + 16'($urandom_range(0, 3)); b = 16'($urandom); end
        2: begin a = 16'($urandom); b = a; end
        default: begin a = 16'($urandom); b = 16'($urandom); end
      endcase
      do_op(c, a, b, ($urandom_range(0, 31) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: ALU

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 16 bits.
REQ-002 clk  input  1  rising-edge clock; one clock for the whole block.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 R1  input  16  operand A; two's-complement signed.
REQ-005 R2  input  16  operand B; two's-complement signed, or shift amount or immediate, depending on alu_code.
REQ-006 alu_code  input  4  operation select.
REQ-007 alu_output  output  16  result; combinational.
REQ-008 overflow_flag  output  1  registered V flag.
REQ-009 zero_flag  output  1  registered Z flag.

Function
REQ-010 alu_output SHALL be purely combinational from R1, R2 and alu_code, with zero-cycle latency; neither clk nor rst affects it.
REQ-011 0000 ADD: the output SHALL be R1+R2, signed-saturated; positive overflow gives 16'h7FFF, negative overflow gives 16'h8000.
REQ-012 0001 SUB: the output SHALL be R1-R2, signed-saturated to the same limits as ADD.
REQ-013 ADD/SUB overflow detection SHALL use operand and raw-sum sign bits; a carry-out alone SHALL NOT count as overflow.
REQ-014 0010 XOR: the output SHALL be R1 ^ R2, bitwise.
REQ-015 0011 RED: the output SHALL be the sign-extended sum (R1[15:8]+R1[7:0])+(R2[15:8]+R2[7:0]) of the signed bytes, computed at 10 bits with no saturation.
REQ-016 0100 SLL: the output SHALL be R1 << R2[3:0], zero-filled.
REQ-017 0101 SRA: the output SHALL be R1 >>> R2[3:0], sign-filled.
REQ-018 0110 ROR: the output SHALL be R1 rotated right by R2[3:0]; an amount of 0 SHALL return R1 unchanged.
REQ-019 0111 PADDSB: the block SHALL perform four independent signed 4-bit adds, R1[4k+3:4k]+R2[4k+3:4k].
REQ-020 PADDSB: each nibble SHALL saturate to 4'h7 or 4'h8; no carry SHALL propagate between nibbles.
REQ-021 1000, 1001 (address calculation): the output SHALL be R1+R2 with modulo-2^16 wrap and no saturation.
REQ-022 1010 LLB: the output SHALL be {R1[15:8], R2[7:0]}.
REQ-023 1011 LHB: the output SHALL be {R2[7:0], R1[7:0]}.
REQ-024 Codes 1100-1111: the output SHALL be R1 + R2 with modulo-2^16 wrap (PC/branch add).
REQ-025 Flag update rule: on each rising clk with rst low, the block SHALL update the flags for the current alu_code as follows.
- ADD or SUB: overflow_flag SHALL take the saturation-occurred value; zero_flag SHALL take (alu_output == 0).
- XOR, SLL, SRA or ROR: zero_flag SHALL take (alu_output == 0); overflow_flag SHALL hold.
- All other codes: both flags SHALL hold.
REQ-026 zero_flag SHALL be computed on the final, post-saturation alu_output.
REQ-027 A saturated result SHALL never set zero_flag.
REQ-028 Operand changes between clock edges SHALL NOT affect the flags until the next rising edge.

Reset
REQ-029 When rst is high at a rising clk, overflow_flag and zero_flag SHALL both become 0; rst SHALL take priority over any flag update.
REQ-030 Reset SHALL have no effect on alu_output, which continues to track its inputs.
REQ-031 The block SHALL have no state other than the two flag bits.

Verification
REQ-032 ADD: R1=16'h7000, R2=16'h2000 -> alu_output 16'h7FFF. After one clk: overflow_flag 1, zero_flag 0.
REQ-033 ADD: R1=16'h8000, R2=16'hFFFF -> alu_output 16'h8000, overflow_flag 1. Then R1=16'h0005, R2=16'hFFFB and clk -> alu_output 0, zero_flag 1, overflow_flag 0.
REQ-034 SUB: R1=16'h8000, R2=16'h0001 -> alu_output 16'h8000. R1=16'h7FFF, R2=16'hFFFF -> alu_output 16'h7FFF. R1=16'h0010, R2=16'h0003 -> alu_output 16'h000D.
REQ-035 XOR sweep: 100 random signed pairs, each checked 5 time units after being applied -> alu_output equals R1^R2 in every case. Also R1=R2=16'hA5A5 plus clk -> zero_flag 1.
REQ-036 Shifts and PADDSB, with R1=16'h8001 and R2[3:0]=4 unless stated otherwise:
- SLL -> 16'h0010.
- SRA -> 16'hF800.
- ROR -> 16'h1800.
- PADDSB with R1=16'h7171, R2=16'h1111 -> 16'h7272.
REQ-037 Reset and hold: set both flags to 1, then assert rst for one clk -> both flags 0. After that, apply LLB (R1=16'h1234, R2=16'h00AB) plus clk -> alu_output 16'h12AB and both flags stay 0.
